ddr2_turnaround_scheduler: RTL and testbench

// - Command-issue stage in front of the DDR2 pads.
// - Accepts READ/WRITE/PRECHARGE/ACTIVATE requests over a valid/ready handshake.
// - Holds each request until WRITE->READ, READ->WRITE, WRITE->PRE and READ->PRE spacing is met.
// - Drives the registered pad command bus and emits DESELECT in every slot with no legal command.

---
 rtl/ddr2_turnaround_scheduler_if.sv | 26 ++
 rtl/ddr2_turnaround_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_ddr2_turnaround_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_turnaround_scheduler_if.sv
// Request handshake and registered DDR2 pad bus of the turnaround scheduler.
// Master drives requests and observes the pads; slave is the scheduler.
interface ddr2_turnaround_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [1:0]  cmd_ba;
  logic [12:0] cmd_addr;
  logic        cke_pad;
  logic        csbar_pad;
  logic        rasbar_pad;
  logic        casbar_pad;
  logic        webar_pad;
  logic [1:0]  ba_pad;
  logic [12:0] addr_pad;

  modport master (
    output cmd_valid, cmd_type, cmd_ba, cmd_addr,
    input  cmd_ready, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad, ba_pad, addr_pad
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_ba, cmd_addr,
    output cmd_ready, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad, ba_pad, addr_pad
  );
endinterface

// File: rtl/ddr2_turnaround_scheduler.sv
// DDR2 command-issue stage: holds one request until WR/RD/PRE turnaround spacing is met.
// Optional feature macro DDR2_TURNAROUND_STATS_EN adds the stall_cycles output.
module ddr2_turnaround_scheduler #(
  parameter int TWTR_MIN = 2,
  parameter int TRTW_MIN = 4,
  parameter int TWR_MIN  = 4,
  parameter int TRTP_MIN = 2,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  ddr2_turnaround_scheduler_if.slave bus
`ifdef DDR2_TURNAROUND_STATS_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_PRE   = 2'b10;
  localparam logic [1:0] CMD_ACT   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWTR_C  = CNT_W'(TWTR_MIN);
  localparam logic [CNT_W-1:0] TRTW_C  = CNT_W'(TRTW_MIN);
  localparam logic [CNT_W-1:0] TWR_C   = CNT_W'(TWR_MIN);
  localparam logic [CNT_W-1:0] TRTP_C  = CNT_W'(TRTP_MIN);

  // Interval counters restart at 1 after their event and stick at all-ones.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic hit);
    logic [CNT_W-1:0] nxt;
    if (hit) begin
      nxt = CNT_ONE;
    end else if (cnt == CNT_MAX) begin
      nxt = cnt;
    end else begin
      nxt = cnt + CNT_ONE;
    end
    return nxt;
  endfunction

  // {CS#, RAS#, CAS#, WE#} for each request type.
  function automatic logic [3:0] pad_encode(input logic [1:0] cmd_type);
    logic [3:0] enc;
    case (cmd_type)
      CMD_READ:  enc = 4'b0101;
      CMD_WRITE: enc = 4'b0100;
      CMD_PRE:   enc = 4'b0010;
      CMD_ACT:   enc = 4'b0011;
      default:   enc = 4'b1111;
    endcase
    return enc;
  endfunction

  logic [0:0]       state_r;
  logic [1:0]       held_type_r;
  logic [1:0]       held_ba_r;
  logic [12:0]      held_addr_r;
  logic             cke_r;
  logic [3:0]       pad_cmd_r;
  logic [1:0]       ba_pad_r;
  logic [12:0]      addr_pad_r;
  logic [CNT_W-1:0] cnt_wr_any_r;
  logic [CNT_W-1:0] cnt_rd_any_r;
  logic [CNT_W-1:0] cnt_wr_r [4];
  logic [CNT_W-1:0] cnt_rd_r [4];

  logic [3:0] bank_ok_s;
  logic       cmd_legal_s;
  logic       issue_s;
  logic       ready_s;
  logic       accept_s;
  logic       wr_hit_s;
  logic       rd_hit_s;

  // Legality of the held request for the next pad slot, ignoring cke.
  always_comb begin
    bank_ok_s   = 4'b0000;
    cmd_legal_s = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bank_ok_s[b] = (cnt_wr_r[b] >= TWR_C) && (cnt_rd_r[b] >= TRTP_C);
    end
    case (held_type_r)
      CMD_READ:  cmd_legal_s = (cnt_wr_any_r >= TWTR_C);
      CMD_WRITE: cmd_legal_s = (cnt_rd_any_r >= TRTW_C);
      CMD_PRE: begin
        if (held_addr_r[10]) begin
          cmd_legal_s = &bank_ok_s;
        end else begin
          cmd_legal_s = bank_ok_s[held_ba_r];
        end
      end
      CMD_ACT:   cmd_legal_s = 1'b1;
      default:   cmd_legal_s = 1'b0;
    endcase
  end

  assign issue_s  = (state_r == ST_PENDING) && cke_r && cmd_legal_s;
  assign ready_s  = (state_r == ST_EMPTY) || issue_s;
  assign accept_s = bus.cmd_valid && ready_s;
  assign wr_hit_s = issue_s && (held_type_r == CMD_WRITE);
  assign rd_hit_s = issue_s && (held_type_r == CMD_READ);

  // Holding register and EMPTY/PENDING state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      held_type_r <= 2'b00;
      held_ba_r   <= 2'b00;
      held_addr_r <= 13'h0000;
    end else if (accept_s) begin
      state_r     <= ST_PENDING;
      held_type_r <= bus.cmd_type;
      held_ba_r   <= bus.cmd_ba;
      held_addr_r <= bus.cmd_addr;
    end else if (issue_s) begin
      state_r     <= ST_EMPTY;
    end else begin
      state_r     <= state_r;
    end
  end

  // Registered pad bus: one slot per issued command, DESELECT otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cke_r      <= 1'b0;
      pad_cmd_r  <= 4'b1111;
      ba_pad_r   <= 2'b00;
      addr_pad_r <= 13'h0000;
    end else begin
      cke_r <= 1'b1;
      if (issue_s) begin
        pad_cmd_r  <= pad_encode(held_type_r);
        ba_pad_r   <= held_ba_r;
        addr_pad_r <= held_addr_r;
      end else begin
        pad_cmd_r  <= 4'b1111;
      end
    end
  end

  // Turnaround interval counters, updated on the edge the command reaches the pads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_wr_any_r <= CNT_MAX;
      cnt_rd_any_r <= CNT_MAX;
      for (int b = 0; b < 4; b++) begin
        cnt_wr_r[b] <= CNT_MAX;
        cnt_rd_r[b] <= CNT_MAX;
      end
    end else begin
      cnt_wr_any_r <= cnt_next(cnt_wr_any_r, wr_hit_s);
      cnt_rd_any_r <= cnt_next(cnt_rd_any_r, rd_hit_s);
      for (int b = 0; b < 4; b++) begin
        cnt_wr_r[b] <= cnt_next(cnt_wr_r[b], wr_hit_s && (held_ba_r == 2'(b)));
        cnt_rd_r[b] <= cnt_next(cnt_rd_r[b], rd_hit_s && (held_ba_r == 2'(b)));
      end
    end
  end

  assign bus.cmd_ready  = ready_s;
  assign bus.cke_pad    = cke_r;
  assign bus.csbar_pad  = pad_cmd_r[3];
  assign bus.rasbar_pad = pad_cmd_r[2];
  assign bus.casbar_pad = pad_cmd_r[1];
  assign bus.webar_pad  = pad_cmd_r[0];
  assign bus.ba_pad     = ba_pad_r;
  assign bus.addr_pad   = addr_pad_r;

`ifdef DDR2_TURNAROUND_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of edges where a held command was blocked by spacing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_PENDING) && cke_r && !cmd_legal_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ddr2_turnaround_scheduler.sv
// Bench for ddr2_turnaround_scheduler: vector table, directed corner sequences and random traffic
// checked against a slot-time reference model.
module tb_ddr2_turnaround_scheduler;
  localparam int TWTR = 2;
  localparam int TRTW = 4;
  localparam int TWR  = 4;
  localparam int TRTP = 2;

  localparam logic [1:0] C_RD  = 2'b00;
  localparam logic [1:0] C_WR  = 2'b01;
  localparam logic [1:0] C_PRE = 2'b10;
  localparam logic [1:0] C_ACT = 2'b11;

  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_DES = 4'b1111;

  logic clk = 1'b0;
  logic reset;
  ddr2_turnaround_scheduler_if bus();
`ifdef DDR2_TURNAROUND_STATS_EN
  logic [15:0] stall_cycles;
`endif

  ddr2_turnaround_scheduler #(
    .TWTR_MIN(TWTR), .TRTW_MIN(TRTW), .TWR_MIN(TWR), .TRTP_MIN(TRTP), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DDR2_TURNAROUND_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0] pad_cmd;
  assign pad_cmd = {bus.csbar_pad, bus.rasbar_pad, bus.casbar_pad, bus.webar_pad};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slot index of the last event of each kind.
  bit          m_cke;
  bit          m_held;
  logic [1:0]  m_type;
  logic [1:0]  m_ba;
  logic [12:0] m_addr;
  int          k;
  int          l_wr_any;
  int          l_rd_any;
  int          l_wr [4];
  int          l_rd [4];
  int          m_stall;

  bit          g_acc;
  int          g_acc_k;
  int          obs_rd_k;
  int          obs_wr_k;
  int          obs_pre_k;

  typedef struct {
    logic        v;
    logic [1:0]  t;
    logic [1:0]  b;
    logic [12:0] a;
    logic        rdy;
    logic [3:0]  pad;
  } vec_t;
  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit bank_ok(input int b);
    return ((k - l_wr[b]) >= TWR) && ((k - l_rd[b]) >= TRTP);
  endfunction

  function automatic bit m_legal();
    bit ok;
    case (m_type)
      C_RD:    ok = (k - l_wr_any) >= TWTR;
      C_WR:    ok = (k - l_rd_any) >= TRTW;
      C_PRE:   ok = m_addr[10] ? (bank_ok(0) && bank_ok(1) && bank_ok(2) && bank_ok(3))
                               : bank_ok(int'(m_ba));
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] enc(input logic [1:0] t);
    logic [3:0] e;
    case (t)
      C_RD:    e = P_RD;
      C_WR:    e = P_WR;
      C_PRE:   e = P_PRE;
      default: e = P_ACT;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    m_cke    = 1'b0;
    m_held   = 1'b0;
    m_stall  = 0;
    l_wr_any = k - 100;
    l_rd_any = k - 100;
    for (int b = 0; b < 4; b++) begin
      l_wr[b] = k - 100;
      l_rd[b] = k - 100;
    end
  endtask

  // One clock: drive request, check ready, advance model and DUT, check pads.
  task automatic step(input bit v, input logic [1:0] t, input logic [1:0] b, input logic [12:0] a,
                      input bit tbl, input bit t_rdy, input logic [3:0] t_pad);
    bit          issue;
    bit          e_rdy;
    int          ke;
    logic [3:0]  e_pad;
    logic [1:0]  e_ba;
    logic [12:0] e_addr;
    bus.cmd_valid = v;
    bus.cmd_type  = t;
    bus.cmd_ba    = b;
    bus.cmd_addr  = a;
    ke     = k;
    issue  = m_held && m_cke && m_legal();
    e_rdy  = !m_held || issue;
    e_ba   = m_ba;
    e_addr = m_addr;
    #1;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_rdy));
    if (tbl) chk("tbl_ready", 32'(bus.cmd_ready), 32'(t_rdy));
    if (m_held && m_cke && !issue && m_stall < 65535) m_stall++;
    e_pad = issue ? enc(m_type) : P_DES;
    if (issue && m_type == C_WR) begin
      l_wr_any   = ke;
      l_wr[m_ba] = ke;
    end
    if (issue && m_type == C_RD) begin
      l_rd_any   = ke;
      l_rd[m_ba] = ke;
    end
    g_acc = v && e_rdy;
    if (g_acc) begin
      g_acc_k = ke;
      m_held  = 1'b1;
      m_type  = t;
      m_ba    = b;
      m_addr  = a;
    end else if (issue) begin
      m_held = 1'b0;
    end
    @(posedge clk);
    m_cke = 1'b1;
    k++;
    #1;
    chk("pad_cmd", 32'(pad_cmd), 32'(e_pad));
    if (issue) begin
      chk("ba_pad", 32'(bus.ba_pad), 32'(e_ba));
      chk("addr_pad", 32'(bus.addr_pad), 32'(e_addr));
    end
    chk("cke_pad", 32'(bus.cke_pad), 32'd1);
    if (tbl) chk("tbl_pad", 32'(pad_cmd), 32'(t_pad));
`ifdef DDR2_TURNAROUND_STATS_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
    if (pad_cmd == P_RD)  obs_rd_k  = ke;
    if (pad_cmd == P_WR)  obs_wr_k  = ke;
    if (pad_cmd == P_PRE) obs_pre_k = ke;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 13'h0000, 1'b0, 1'b0, 4'h0);
  endtask

  // Hold a request valid until accepted, bounded.
  task automatic send(input logic [1:0] t, input logic [1:0] b, input logic [12:0] a);
    int tries = 0;
    g_acc = 1'b0;
    while (!g_acc && tries < 32) begin
      step(1'b1, t, b, a, 1'b0, 1'b0, 4'h0);
      tries++;
    end
    chk("send_accepted", 32'(g_acc), 32'd1);
  endtask

  task automatic apply_reset();
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_pad_cmd", 32'(pad_cmd), 32'(P_DES));
    chk("rst_ba_pad", 32'(bus.ba_pad), 32'd0);
    chk("rst_addr_pad", 32'(bus.addr_pad), 32'd0);
    chk("rst_cke_pad", 32'(bus.cke_pad), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_cke_held", 32'(bus.cke_pad), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef DDR2_TURNAROUND_STATS_EN
    int stall0;
`endif
    vecs = '{
      '{1'b1, C_WR,  2'd0, 13'h0000, 1'b1, P_DES},
      '{1'b1, C_RD,  2'd1, 13'h0010, 1'b1, P_WR },
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b0, P_DES},
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b1, P_RD },
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b1, P_DES},
      '{1'b1, C_RD,  2'd2, 13'h0020, 1'b1, P_DES},
      '{1'b1, C_WR,  2'd2, 13'h0030, 1'b1, P_RD },
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b0, P_DES},
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b0, P_DES},
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b0, P_DES},
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b1, P_WR },
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b1, P_DES},
      '{1'b1, C_WR,  2'd1, 13'h0040, 1'b1, P_DES},
      '{1'b1, C_PRE, 2'd1, 13'h0000, 1'b1, P_WR },
      '{1'b1, C_PRE, 2'd3, 13'h0000, 1'b0, P_DES},
      '{1'b1, C_PRE, 2'd3, 13'h0000, 1'b0, P_DES},
      '{1'b1, C_PRE, 2'd3, 13'h0000, 1'b0, P_DES},
      '{1'b1, C_PRE, 2'd3, 13'h0000, 1'b1, P_PRE},
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b1, P_PRE},
      '{1'b0, C_RD,  2'd0, 13'h0000, 1'b1, P_DES}
    };
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'b00;
    bus.cmd_ba    = 2'b00;
    bus.cmd_addr  = 13'h0000;
    k = 0;
    obs_rd_k = -1;
    obs_wr_k = -1;
    obs_pre_k = -1;
    model_reset();
    #2;
    apply_reset();
    idle(2);

    // WRITE->READ, READ->WRITE, WRITE->PRE then back-to-back PRE.
`ifdef DDR2_TURNAROUND_STATS_EN
    stall0 = int'(stall_cycles);
`endif
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].v, vecs[i].t, vecs[i].b, vecs[i].a, 1'b1, vecs[i].rdy, vecs[i].pad);
    end
`ifdef DDR2_TURNAROUND_STATS_EN
    chk("tbl_stall_total", 32'(int'(stall_cycles) - stall0), 32'd7);
`endif

    // Saturated history: WRITE issues at minimum latency after long idle.
    send(C_RD, 2'd0, 13'h0100);
    idle(20);
    send(C_WR, 2'd1, 13'h0200);
    idle(1);
    chk("wr_min_latency", 32'(obs_wr_k - g_acc_k), 32'd1);
    idle(4);
    send(C_RD, 2'd0, 13'h0300);
    send(C_PRE, 2'd3, 13'h0400);
    idle(6);
    chk("pre_all_after_rd", 32'(obs_pre_k - obs_rd_k), 32'd2);

    // Reset while a WRITE is held behind a READ.
    send(C_RD, 2'd2, 13'h0011);
    send(C_WR, 2'd2, 13'h0022);
    chk("pre_reset_rd_on_pads", 32'(pad_cmd), 32'(P_RD));
    obs_wr_k = -1;
    apply_reset();
    idle(8);
    chk("dropped_write", 32'(obs_wr_k), 32'hFFFF_FFFF);
    send(C_WR, 2'd0, 13'h0055);
    idle(1);
    chk("post_reset_wr", 32'(obs_wr_k - g_acc_k), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           13'($urandom), 1'b0, 1'b0, 4'h0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
